zipo_mem_arbiter: RTL
=====================

# zipo_mem_arbiter

Two-requester arbiter and sequencer for the zipocpu single 64-bit memory port (`rw`/`addr`/`write`/`read`). Instruction fetch and data load/store requests share the port. The block serialises them, drives address, data and direction for a fixed memory latency, and returns read data with a one-cycle completion pulse. It sits between the core's fetch/load-store logic and the memory.

## Interface
- `MEM_LATENCY`, 1: cycles from the first cycle `mem_addr` is driven to the cycle `mem_read` is valid. Legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `i_req` in 1: fetch request, level, held until `i_done`.
- `i_addr` in 64: fetch address. Must be stable while `i_req` is high.
- `i_rdata` out 64: fetch read data, valid when `i_done` is high, held after.
- `i_done` out 1: fetch completion, one-cycle pulse.
- `d_req` in 1: data request, level, held until `d_done`.
- `d_rw` in 1: 1 = write, 0 = read.
- `d_addr` in 64: data address.
- `d_wdata` in 64: write data.
- `d_rdata` out 64: load data, valid when `d_done` is high. Not updated by writes.
- `d_done` out 1: data completion, one-cycle pulse.
- `mem_rw` out 1: memory direction, 1 = write.
- `mem_addr` out 64: memory address.
- `mem_write` out 64: memory write data.
- `mem_read` in 64: memory read data.
- `busy` out 1: high in the WAIT and RESP states.

## Operation
- FSM states: IDLE, WAIT, RESP. Encoding is 2 bits.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner (see Arbitration).
  - Register `mem_addr` from the winner's address.
  - Register `mem_rw`: `d_rw` for a data winner, 0 for a fetch winner.
  - Register `mem_write` from `d_wdata` (data winner only; otherwise unchanged).
  - Load the wait counter with `MEM_LATENCY`-1, record the winner, go to WAIT.
- **WAIT**
  - Hold all `mem_*` outputs.
  - Decrement the counter each cycle.
  - When the counter is 0: capture `mem_read` into the winner's rdata (reads only), set the winner's done, set `mem_rw` to 0, go to RESP.
- **RESP**
  - The done signal is high for exactly this cycle.
  - No request is sampled in this state.
  - Go to IDLE.
- **Requester rule:** a requester may drop its req or present a new one by the end of the RESP cycle. A req still high in IDLE is a new request.
- **Arbitration, default:** fixed priority, data over fetch.
- **Counter:** 4 bits, saturates at 0, never wraps.
- **Reset:** any state returns to IDLE immediately. The transaction in flight is abandoned and no done is issued.
- **Reset values:** `mem_rw`=0, `mem_addr`=0, `mem_write`=0, `i_rdata`=0, `d_rdata`=0, `i_done`=0, `d_done`=0, `busy`=0, counter=0, last-grant=fetch.

## Timing
- Request sampled at edge N. `mem_*` are valid after edge N.
- `mem_read` is captured at edge N+`MEM_LATENCY`.
- Done is high in cycle N+`MEM_LATENCY`..N+`MEM_LATENCY`+1.
- Request-to-done latency is `MEM_LATENCY`+1 cycles.
- Back-to-back grant: the next request is sampled at edge N+`MEM_LATENCY`+2. Peak throughput is one access per `MEM_LATENCY`+2 cycles.
- Simultaneous requests in IDLE: one wins; the loser stays pending and is granted next, with no starvation under the round-robin option.
- `mem_rw` is high only during WAIT of a data write. It is never high in IDLE or RESP.
- Request changes during WAIT or RESP are ignored.

## Configuration
- Macro: `ZIPO_ARB_ROUND_ROBIN_EN`.
- **Defined:** on a tie, the requester not recorded as last-grant wins. Last-grant updates on every grant and resets to fetch, so the first tie after reset goes to data.
- **Undefined:** fixed priority, data always wins ties. The last-grant register is not built.

## Structure
- The shared include beside `instructions.v` holds:
  - FSM state constants `ZIPO_ARB_IDLE`, `ZIPO_ARB_WAIT`, `ZIPO_ARB_RESP`;
  - requester ID constants `ZIPO_REQ_FETCH`=0, `ZIPO_REQ_DATA`=1.
- One sub-module, `zipo_arb_pick`: combinational winner select from `i_req`, `d_req` and last-grant.
- The FSM, counter and output registers stay in the top module.

## Test plan
- **Single fetch:** `MEM_LATENCY`=1, `i_req` with `i_addr`=0x10, memory returns 0xDEAD → `mem_addr`=0x10 and `mem_rw`=0 for 1 cycle; `i_done` 2 cycles after the request, `i_rdata`=0xDEAD.
- **Data write:** `MEM_LATENCY`=3, `d_rw`=1, `d_addr`=0x200, `d_wdata`=0x55 → `mem_rw`=1 for exactly 3 cycles, `mem_write`=0x55, `d_done` at +4 cycles, `d_rdata` unchanged.
- **Tie, macro undefined:** `i_req` and `d_req` both held high for 3 grants → grant order data, data, data; fetch starves. Requirement: `i_done` is never asserted while `d_req` stays high.
- **Tie, `ZIPO_ARB_ROUND_ROBIN_EN`:** both held high → grant order data, fetch, data, fetch, with one done pulse per grant.
- **Reset mid-WAIT:** assert `rst` in the second WAIT cycle of a `MEM_LATENCY`=3 read → all outputs return to their reset values asynchronously, no done pulse; after release, a new request completes normally.
- **Back-to-back:** `MEM_LATENCY`=2, `i_req` held high continuously → `i_done` every 4 cycles, with no gap beyond the RESP cycle.

Source files
------------

// File: rtl/zipo_mem_arbiter_pkg.sv
// ============================================================================
// Module  : zipo_mem_arbiter_pkg
// Brief   : Shared FSM state and requester ID constants for the memory arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package zipo_mem_arbiter_pkg;

    localparam logic [1:0] ZIPO_ARB_IDLE = 2'd0;
    localparam logic [1:0] ZIPO_ARB_WAIT = 2'd1;
    localparam logic [1:0] ZIPO_ARB_RESP = 2'd2;

    localparam logic ZIPO_REQ_FETCH = 1'b0;
    localparam logic ZIPO_REQ_DATA  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/zipo_arb_pick.sv
// ============================================================================
// Module  : zipo_arb_pick
// Brief   : Combinational winner select between fetch and data requesters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zipo_arb_pick
    import zipo_mem_arbiter_pkg::*;
(
    input  logic i_fetch_req,
    input  logic i_data_req,
    input  logic i_last_grant,
    output logic o_valid,
    output logic o_grant
);

    always_comb begin
        o_valid = i_fetch_req | i_data_req;
        // On a tie the requester that did not win last time gets the port.
        if (i_fetch_req && i_data_req) begin
            o_grant = (i_last_grant == ZIPO_REQ_FETCH) ? ZIPO_REQ_DATA : ZIPO_REQ_FETCH;
        end else if (i_data_req) begin
            o_grant = ZIPO_REQ_DATA;
        end else begin
            o_grant = ZIPO_REQ_FETCH;
        end
    end

endmodule

`default_nettype wire

// File: rtl/zipo_mem_arbiter.sv
// ============================================================================
// Module  : zipo_mem_arbiter
// Brief   : Fetch/data arbiter and fixed-latency sequencer for the 64-bit
//           memory port. Define ZIPO_ARB_ROUND_ROBIN_EN for round-robin ties.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module zipo_mem_arbiter
    import zipo_mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [63:0] i_addr,
    output logic [63:0] i_rdata,
    output logic        i_done,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic        mem_rw,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_write,
    input  logic [63:0] mem_read,
    output logic        busy
);

    localparam logic [3:0] c_cnt_load = 4'(MEM_LATENCY - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_winner;
    logic       w_last_grant;
    logic       w_valid;
    logic       w_grant;

    zipo_arb_pick u_pick (
        .i_fetch_req  (i_req),
        .i_data_req   (d_req),
        .i_last_grant (w_last_grant),
        .o_valid      (w_valid),
        .o_grant      (w_grant)
    );

`ifdef ZIPO_ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= ZIPO_REQ_FETCH;
        end else if (r_state == ZIPO_ARB_IDLE && w_valid) begin
            r_last_grant <= w_grant;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    // A constant fetch last-grant makes every tie resolve to data.
    assign w_last_grant = ZIPO_REQ_FETCH;
`endif

    assign busy = (r_state == ZIPO_ARB_WAIT) || (r_state == ZIPO_ARB_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ZIPO_ARB_IDLE;
            r_cnt     <= 4'd0;
            r_winner  <= ZIPO_REQ_FETCH;
            mem_rw    <= 1'b0;
            mem_addr  <= 64'd0;
            mem_write <= 64'd0;
            i_rdata   <= 64'd0;
            d_rdata   <= 64'd0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (r_state)
                ZIPO_ARB_IDLE: begin
                    if (w_valid) begin
                        r_winner <= w_grant;
                        r_cnt    <= c_cnt_load;
                        r_state  <= ZIPO_ARB_WAIT;
                        if (w_grant == ZIPO_REQ_DATA) begin
                            mem_addr  <= d_addr;
                            mem_rw    <= d_rw;
                            mem_write <= d_wdata;
                        end else begin
                            mem_addr <= i_addr;
                            mem_rw   <= 1'b0;
                        end
                    end
                end
                ZIPO_ARB_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        if (r_winner == ZIPO_REQ_FETCH) begin
                            i_rdata <= mem_read;
                            i_done  <= 1'b1;
                        end else begin
                            // Writes leave the load data register untouched.
                            if (!mem_rw) begin
                                d_rdata <= mem_read;
                            end
                            d_done <= 1'b1;
                        end
                        mem_rw  <= 1'b0;
                        r_state <= ZIPO_ARB_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ZIPO_ARB_RESP: begin
                    r_state <= ZIPO_ARB_IDLE;
                end
                default: begin
                    r_state <= ZIPO_ARB_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
